// File: rtl/rc_pkt_ctrl.sv
// Receive-path sequencer for the USB receiver: frames rc_crc around one packet,
// collects the CRC verdict, retries corrupted packets and reports the outcome.
module rc_pkt_ctrl #(
  parameter int unsigned DATA_BITS = 88,
  parameter int unsigned HS_BITS   = 8,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_start,
  input  logic       rx_is_data,
  input  logic       abort,
  input  logic       sync_det,
  input  logic       bit_valid,
  input  logic       crc_valid,
  input  logic       crc_ok,
  output logic       start_rc_crc,
  output logic       end_rc_crc,
  output logic       retry_req,
  output logic       rx_done,
  output logic       rx_ok,
  output logic [1:0] retry_cnt
);

  localparam logic [6:0] DataLast   = 7'(DATA_BITS - 1);
  localparam logic [6:0] HsLast     = 7'(HS_BITS - 1);
  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT);
  localparam logic [1:0] RetryLim   = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    StIdle, StWaitSync, StRecv, StFinish, StCheck, StRetry, StDone
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] last_q, last_d;        // index of the final bit (len-1)
  logic [6:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] retry_cnt_q, retry_cnt_d;
  logic       start_q, start_d;
  logic       end_q, end_d;
  logic       retry_req_q, retry_req_d;
  logic       rx_done_q, rx_done_d;
  logic       rx_ok_q, rx_ok_d;
  logic       fail;
  logic       timed_out;
  logic [7:0] timer_inc;

  assign timed_out = (timer_q >= TimeoutLim);
  // Saturating increment so the timer never wraps back below the limit.
  assign timer_inc = timed_out ? timer_q : timer_q + 8'd1;

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    bit_cnt_d   = bit_cnt_q;
    timer_d     = timer_q;
    retry_cnt_d = retry_cnt_q;
    start_d     = 1'b0;
    end_d       = 1'b0;
    retry_req_d = 1'b0;
    rx_done_d   = 1'b0;
    rx_ok_d     = rx_ok_q;
    fail        = 1'b0;

    unique case (state_q)
      StIdle: begin
        rx_ok_d = 1'b0;
        if (rx_start) begin
          last_d      = rx_is_data ? DataLast : HsLast;
          retry_cnt_d = 2'd0;
          bit_cnt_d   = 7'd0;
          timer_d     = 8'd0;
          state_d     = StWaitSync;
        end
      end
      StWaitSync: begin
        if (sync_det) begin
          start_d   = 1'b1;
          bit_cnt_d = 7'd0;
          timer_d   = 8'd0;
          state_d   = StRecv;
        end else if (timed_out) begin
          fail = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      StRecv: begin
        // A bit arriving on the timeout cycle still counts.
        if (bit_valid) begin
          timer_d = 8'd0;
          if (bit_cnt_q == last_q) begin
            end_d   = 1'b1;
            state_d = StFinish;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end else if (timed_out) begin
          fail = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      StFinish: begin
        timer_d = 8'd0;
        state_d = StCheck;
      end
      StCheck: begin
        // The verdict takes precedence over a simultaneous timeout.
        if (crc_valid) begin
          if (crc_ok) begin
            rx_ok_d = 1'b1;
            state_d = StDone;
          end else begin
            fail = 1'b1;
          end
        end else if (timed_out) begin
          fail = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end
      StRetry: begin
        retry_req_d = 1'b1;
        if (retry_cnt_q < RetryLim) begin
          retry_cnt_d = retry_cnt_q + 2'd1;
        end
        timer_d = 8'd0;
        state_d = StWaitSync;
      end
      StDone: begin
        rx_done_d = 1'b1;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (fail) begin
      if (retry_cnt_q < RetryLim) begin
        state_d = StRetry;
      end else begin
        rx_ok_d = 1'b0;
        state_d = StDone;
      end
    end

    // abort overrides everything and suppresses any completion report.
    if (abort) begin
      state_d     = StIdle;
      bit_cnt_d   = 7'd0;
      timer_d     = 8'd0;
      start_d     = 1'b0;
      end_d       = 1'b0;
      retry_req_d = 1'b0;
      rx_done_d   = 1'b0;
      rx_ok_d     = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_q      <= 7'd0;
      bit_cnt_q   <= 7'd0;
      timer_q     <= 8'd0;
      retry_cnt_q <= 2'd0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      retry_req_q <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      retry_cnt_q <= retry_cnt_d;
      start_q     <= start_d;
      end_q       <= end_d;
      retry_req_q <= retry_req_d;
      rx_done_q   <= rx_done_d;
      rx_ok_q     <= rx_ok_d;
    end
  end

  assign start_rc_crc = start_q;
  assign end_rc_crc   = end_q;
  assign retry_req    = retry_req_q;
  assign rx_done      = rx_done_q;
  assign rx_ok        = rx_ok_q;
  assign retry_cnt    = retry_cnt_q;

endmodule

// File: tb/tb_rc_pkt_ctrl.sv
// Directed bench for rc_pkt_ctrl: a per-cycle vector table for a handshake
// packet, then hand-written sequences for retries, timeouts and interruptions.
module tb_rc_pkt_ctrl;

  logic       clk;
  logic       rst_n;
  logic       rx_start;
  logic       rx_is_data;
  logic       abort;
  logic       sync_det;
  logic       bit_valid;
  logic       crc_valid;
  logic       crc_ok;
  logic       start_rc_crc;
  logic       end_rc_crc;
  logic       retry_req;
  logic       rx_done;
  logic       rx_ok;
  logic [1:0] retry_cnt;

  rc_pkt_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_start     (rx_start),
    .rx_is_data   (rx_is_data),
    .abort        (abort),
    .sync_det     (sync_det),
    .bit_valid    (bit_valid),
    .crc_valid    (crc_valid),
    .crc_ok       (crc_ok),
    .start_rc_crc (start_rc_crc),
    .end_rc_crc   (end_rc_crc),
    .retry_req    (retry_req),
    .rx_done      (rx_done),
    .rx_ok        (rx_ok),
    .retry_cnt    (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {start_rc_crc, end_rc_crc, retry_req, rx_done, rx_ok}
  logic [4:0] outs;
  assign outs = {start_rc_crc, end_rc_crc, retry_req, rx_done, rx_ok};

  int n_checks;
  int n_fails;

  // Free-running pulse counters; tests compare differences against snapshots.
  int n_start, n_end, n_retry, n_done;
  initial begin
    n_start = 0;
    n_end   = 0;
    n_retry = 0;
    n_done  = 0;
  end
  always @(posedge clk) begin
    if (start_rc_crc) n_start <= n_start + 1;
    if (end_rc_crc)   n_end   <= n_end + 1;
    if (retry_req)    n_retry <= n_retry + 1;
    if (rx_done)      n_done  <= n_done + 1;
  end

  // in = {rx_start, rx_is_data, sync_det, bit_valid, crc_valid, crc_ok}
  typedef struct {
    logic [5:0] in;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [5:0] in, input logic [4:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_pkt(input logic is_data);
    rx_start   = 1'b1;
    rx_is_data = is_data;
    tick();
    rx_start   = 1'b0;
    rx_is_data = 1'b0;
  endtask

  task automatic sync();
    sync_det = 1'b1;
    tick();
    sync_det = 1'b0;
  endtask

  task automatic bits(input int n);
    bit_valid = 1'b1;
    ticks(n);
    bit_valid = 1'b0;
  endtask

  task automatic verdict(input logic ok);
    crc_valid = 1'b1;
    crc_ok    = ok;
    tick();
    crc_valid = 1'b0;
    crc_ok    = 1'b0;
  endtask

  // SYNC, n bits, the FINISH cycle, then the verdict in CHECK.
  task automatic attempt(input int n, input logic ok);
    sync();
    bits(n);
    tick();
    verdict(ok);
  endtask

  int b_start, b_end, b_retry, b_done;
  task automatic snap();
    b_start = n_start;
    b_end   = n_end;
    b_retry = n_retry;
    b_done  = n_done;
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    rst_n      = 1'b0;
    rx_start   = 1'b0;
    rx_is_data = 1'b0;
    abort      = 1'b0;
    sync_det   = 1'b0;
    bit_valid  = 1'b0;
    crc_valid  = 1'b0;
    crc_ok     = 1'b0;

    // Handshake packet cycle by cycle; bit_valid on the sync_det cycle is ignored.
    add_vec(6'b100000, 5'b00000);
    add_vec(6'b001100, 5'b10000);
    for (int i = 0; i < 7; i++) add_vec(6'b000100, 5'b00000);
    add_vec(6'b000100, 5'b01000);
    add_vec(6'b000000, 5'b00000);
    add_vec(6'b000011, 5'b00001);
    add_vec(6'b000000, 5'b00011);
    add_vec(6'b000000, 5'b00000);

    ticks(2);
    rst_n = 1'b1;
    check("reset_outs", outs, 5'b00000);
    check("reset_retry_cnt", retry_cnt, 2'd0);

    // Handshake table.
    for (int i = 0; i < vecs.size(); i++) begin
      {rx_start, rx_is_data, sync_det, bit_valid, crc_valid, crc_ok} = vecs[i].in;
      tick();
      check($sformatf("hs_vec%0d", i), outs, vecs[i].exp);
    end
    {rx_start, rx_is_data, sync_det, bit_valid, crc_valid, crc_ok} = 6'b0;

    // Good DATA packet.
    snap();
    start_pkt(1'b1);
    sync();
    check("data_start_lat", start_rc_crc, 1'b1);
    bits(87);
    check("data_end_early", end_rc_crc, 1'b0);
    bits(1);
    check("data_end_lat", end_rc_crc, 1'b1);
    tick();
    verdict(1'b1);
    check("data_done_early", rx_done, 1'b0);
    tick();
    check("data_done", outs, 5'b00011);
    tick();
    check("data_n_start", n_start - b_start, 1);
    check("data_n_end", n_end - b_end, 1);
    check("data_n_retry", n_retry - b_retry, 0);
    check("data_n_done", n_done - b_done, 1);
    check("data_retry_cnt", retry_cnt, 2'd0);

    // Two bad CRCs, then good.
    snap();
    start_pkt(1'b1);
    attempt(88, 1'b0);
    tick();
    check("r2_req1", retry_req, 1'b1);
    check("r2_cnt1", retry_cnt, 2'd1);
    attempt(88, 1'b0);
    tick();
    check("r2_cnt2", retry_cnt, 2'd2);
    attempt(88, 1'b1);
    tick();
    check("r2_done", outs, 5'b00011);
    tick();
    check("r2_n_retry", n_retry - b_retry, 2);
    check("r2_retry_cnt", retry_cnt, 2'd2);

    // Four bad CRCs: failure after three retries.
    snap();
    start_pkt(1'b1);
    for (int a = 0; a < 3; a++) begin
      attempt(88, 1'b0);
      tick();
    end
    attempt(88, 1'b0);
    tick();
    check("r3_done_fail", outs, 5'b00010);
    tick();
    check("r3_n_retry", n_retry - b_retry, 3);
    check("r3_retry_cnt", retry_cnt, 2'd3);
    check("r3_n_done", n_done - b_done, 1);

    // SYNC timeout.
    start_pkt(1'b1);
    ticks(256);
    check("sync_to_early", retry_req, 1'b0);
    tick();
    check("sync_to_req", retry_req, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Mid-packet stall at bit 40, then a full packet after resync.
    snap();
    start_pkt(1'b1);
    sync();
    bits(40);
    ticks(256);
    check("stall_early", retry_req, 1'b0);
    tick();
    check("stall_req", retry_req, 1'b1);
    sync();
    bits(87);
    check("stall_cnt_restart", end_rc_crc, 1'b0);
    bits(1);
    check("stall_end", end_rc_crc, 1'b1);
    tick();
    verdict(1'b1);
    tick();
    check("stall_done", outs, 5'b00011);
    check("stall_retry_cnt", retry_cnt, 2'd1);

    // Bit on the timeout cycle wins; verdict on the timeout cycle wins.
    snap();
    start_pkt(1'b1);
    sync();
    bits(10);
    ticks(255);
    bits(77);
    check("bitwin_end_early", end_rc_crc, 1'b0);
    bits(1);
    check("bitwin_end", end_rc_crc, 1'b1);
    ticks(256);
    verdict(1'b1);
    tick();
    check("crcwin_done", outs, 5'b00011);
    tick();
    check("win_n_retry", n_retry - b_retry, 0);

    // abort at bit 50: back to IDLE, nothing reported even after a long wait.
    snap();
    start_pkt(1'b1);
    sync();
    bits(50);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_outs", outs, 5'b00000);
    ticks(300);
    check("abort_n_done", n_done - b_done, 0);
    check("abort_n_retry", n_retry - b_retry, 0);

    // Reset while in CHECK, with a retry already used.
    snap();
    start_pkt(1'b0);
    attempt(8, 1'b0);
    tick();
    sync();
    bits(8);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_chk_outs", outs, 5'b00000);
    check("rst_chk_retry_cnt", retry_cnt, 2'd0);
    verdict(1'b1);
    ticks(3);
    check("rst_chk_n_done", n_done - b_done, 0);

    // Normal packet after the interruptions.
    snap();
    start_pkt(1'b0);
    attempt(8, 1'b1);
    tick();
    check("after_done", outs, 5'b00011);
    tick();
    check("after_n_done", n_done - b_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
